// File: rtl/matmul_seq_ctrl.sv
// Sequencing controller for the FP matrix-multiply engine: walks C row-major,
// streams K A/B reads per element into the MAC and writes results to C BRAM.
// Optional: define MATMUL_SEQ_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
module matmul_seq_ctrl #(
   parameter int MAX_M       = 4,
   parameter int MAX_K       = 4,
   parameter int MAX_N       = 4,
   parameter int DIM_W       = 8,
   parameter int ADDR_W      = 4,
   parameter int ACC_TIMEOUT = 255
) (
   input  logic              s00_axi_aclk,
   input  logic              s00_axi_aresetn,
   input  logic              start,
   input  logic [DIM_W-1:0]  dim_m,
   input  logic [DIM_W-1:0]  dim_k,
   input  logic [DIM_W-1:0]  dim_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_rd_addr,
   output logic              mac_valid,
   output logic              mac_first,
   output logic              mac_last,
   input  logic              acc_valid,
   input  logic [31:0]       acc_data,
   output logic              c_wr_en,
   output logic [ADDR_W-1:0] c_wr_addr,
   output logic [31:0]       c_wr_data
`ifdef MATMUL_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int TO_W = $clog2(ACC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, ISSUE, DRAIN, WAIT_ACC, WRITE, FIN
   } state_t;

   state_t state_q, state_d;

   logic [DIM_W-1:0]  dm_q, dk_q, dn_q;
   logic [ADDR_W-1:0] k_cnt, j_cnt, i_cnt;
   logic [ADDR_W-1:0] row_base, b_addr, c_addr;
   logic [TO_W-1:0]   wait_cnt;
   logic [31:0]       acc_q;
   logic              busy_q, done_q, err_q;
   logic              mac_valid_q, mac_first_q, mac_last_q;

   logic              dims_bad, k_last, j_last, i_last, timeout_hit;
   logic [ADDR_W-1:0] k_a, n_a;

   assign dims_bad = (dm_q == '0) || (dm_q > DIM_W'(MAX_M)) ||
                     (dk_q == '0) || (dk_q > DIM_W'(MAX_K)) ||
                     (dn_q == '0) || (dn_q > DIM_W'(MAX_N));

   // Dimensions are range-checked before any use, so the low bits suffice here.
   assign k_a         = dk_q[ADDR_W-1:0];
   assign n_a         = dn_q[ADDR_W-1:0];
   assign k_last      = (k_cnt == k_a - ADDR_W'(1));
   assign j_last      = (j_cnt == n_a - ADDR_W'(1));
   assign i_last      = (i_cnt == dm_q[ADDR_W-1:0] - ADDR_W'(1));
   assign timeout_hit = (wait_cnt == TO_W'(ACC_TIMEOUT - 1));

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) state_q <= IDLE;
      else                  state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      a_rd_en   = 1'b0;
      a_rd_addr = '0;
      b_rd_en   = 1'b0;
      b_rd_addr = '0;
      c_wr_en   = 1'b0;
      c_wr_addr = '0;
      c_wr_data = '0;
      unique case (state_q)
         IDLE:     if (start) state_d = CHECK;
         CHECK:    state_d = dims_bad ? FIN : ISSUE;
         ISSUE: begin
            a_rd_en   = 1'b1;
            a_rd_addr = row_base + k_cnt;
            b_rd_en   = 1'b1;
            b_rd_addr = b_addr;
            if (k_last) state_d = DRAIN;
         end
         DRAIN:    state_d = WAIT_ACC;
         WAIT_ACC: begin
            if (acc_valid)        state_d = WRITE;
            else if (timeout_hit) state_d = FIN;
         end
         WRITE: begin
            c_wr_en   = 1'b1;
            c_wr_addr = c_addr;
            c_wr_data = acc_q;
            state_d   = (i_last && j_last) ? FIN : ISSUE;
         end
         FIN:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         dm_q        <= '0;
         dk_q        <= '0;
         dn_q        <= '0;
         k_cnt       <= '0;
         j_cnt       <= '0;
         i_cnt       <= '0;
         row_base    <= '0;
         b_addr      <= '0;
         c_addr      <= '0;
         wait_cnt    <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_first_q <= 1'b0;
         mac_last_q  <= 1'b0;
      end else begin
         // One-cycle BRAM latency: MAC controls trail the read strobe by a cycle.
         mac_valid_q <= (state_q == ISSUE);
         mac_first_q <= (state_q == ISSUE) && (k_cnt == '0);
         mac_last_q  <= (state_q == ISSUE) && k_last;

         case (state_q)
            IDLE: begin
               if (start) begin
                  dm_q   <= dim_m;
                  dk_q   <= dim_k;
                  dn_q   <= dim_n;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
               end
            end
            CHECK: begin
               if (dims_bad) begin
                  err_q <= 1'b1;
               end else begin
                  k_cnt    <= '0;
                  j_cnt    <= '0;
                  i_cnt    <= '0;
                  row_base <= '0;
                  b_addr   <= '0;
                  c_addr   <= '0;
               end
            end
            ISSUE: begin
               if (k_last) begin
                  k_cnt <= '0;
               end else begin
                  k_cnt  <= k_cnt + ADDR_W'(1);
                  b_addr <= b_addr + n_a;
               end
            end
            DRAIN: wait_cnt <= '0;
            WAIT_ACC: begin
               if (acc_valid)        acc_q    <= acc_data;
               else if (timeout_hit) err_q    <= 1'b1;
               else                  wait_cnt <= wait_cnt + TO_W'(1);
            end
            WRITE: begin
               c_addr <= c_addr + ADDR_W'(1);
               if (j_last) begin
                  j_cnt    <= '0;
                  i_cnt    <= i_cnt + ADDR_W'(1);
                  row_base <= row_base + k_a;
                  b_addr   <= '0;
               end else begin
                  j_cnt  <= j_cnt + ADDR_W'(1);
                  b_addr <= j_cnt + ADDR_W'(1);
               end
            end
            default: ;
         endcase

         // Status flips on entry to FIN so done is already visible during FIN.
         if (state_d == FIN) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

`ifdef MATMUL_SEQ_PERF_CNT_EN
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn)                 perf_cycles <= '0;
      else if (state_q == IDLE && start)    perf_cycles <= '0;
      else if (busy_q && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
   end
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mac_valid = mac_valid_q;
   assign mac_first = mac_first_q;
   assign mac_last  = mac_last_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: BRAM and fixed-latency MAC models
// with per-cycle address, framing and write-data checks.
module tb_matmul_seq_ctrl;

   localparam int L = 3;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  dim_m, dim_k, dim_n;
   logic        busy, done, err;
   logic        a_rd_en, b_rd_en, mac_valid, mac_first, mac_last;
   logic [3:0]  a_rd_addr, b_rd_addr, c_wr_addr;
   logic        acc_valid;
   logic [31:0] acc_data;
   logic        c_wr_en;
   logic [31:0] c_wr_data;

   matmul_seq_ctrl dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .start           (start),
      .dim_m           (dim_m),
      .dim_k           (dim_k),
      .dim_n           (dim_n),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .a_rd_en         (a_rd_en),
      .a_rd_addr       (a_rd_addr),
      .b_rd_en         (b_rd_en),
      .b_rd_addr       (b_rd_addr),
      .mac_valid       (mac_valid),
      .mac_first       (mac_first),
      .mac_last        (mac_last),
      .acc_valid       (acc_valid),
      .acc_data        (acc_data),
      .c_wr_en         (c_wr_en),
      .c_wr_addr       (c_wr_addr),
      .c_wr_data       (c_wr_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_chk = 0;
   int          n_pass = 0;
   int          em, ek, en;
   int          pend, term, exp_i, exp_j, exp_k, wr_cnt, rd_cnt;
   bit          mac_never;
   logic [31:0] mac_sum, b_q;
   logic [31:0] b_mem [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Expected C element: A is all 1.0, so C[i][j] is the column sum of B.
   // Data is opaque to the controller, so integer sums stand in for floats.
   function automatic logic [31:0] exp_c(input int idx);
      logic [31:0] s = '0;
      for (int k = 0; k < ek; k++) s += b_mem[k * en + (idx % en)];
      return s;
   endfunction

   function automatic logic any_out();
      return |{busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, mac_valid,
               mac_first, mac_last, c_wr_en, c_wr_addr, c_wr_data};
   endfunction

   // BRAM + MAC model and per-cycle monitor, all evaluated mid-cycle.
   initial begin
      acc_valid = 1'b0;
      acc_data  = '0;
      pend      = 0;
      term      = 0;
      mac_sum   = '0;
      b_q       = '0;
      forever begin
         @(negedge clk);
         acc_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && !mac_never) begin
               acc_valid = 1'b1;
               acc_data  = mac_sum;
            end
         end
         if (mac_valid) begin
            check("mac_first", mac_first, term == 0);
            check("mac_last", mac_last, term == ek - 1);
            mac_sum = (mac_first ? 32'd0 : mac_sum) + b_q;
            term    = (term == ek - 1) ? 0 : term + 1;
            if (mac_last) pend = L;
         end
         if (a_rd_en) begin
            rd_cnt++;
            check("a_rd_addr", a_rd_addr, exp_i * ek + exp_k);
            check("b_rd_addr", b_rd_addr, exp_k * en + exp_j);
            check("b_rd_en", b_rd_en, 1);
            b_q   = b_mem[b_rd_addr];
            exp_k = (exp_k == ek - 1) ? 0 : exp_k + 1;
         end
         if (c_wr_en) begin
            check("c_wr_addr", c_wr_addr, wr_cnt);
            check("c_wr_data", c_wr_data, exp_c(wr_cnt));
            wr_cnt++;
            exp_j++;
            if (exp_j == en) begin
               exp_j = 0;
               exp_i++;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // Runs one sequence; cyc is the cycle (start cycle = 0) where done is seen.
   // inj_el >= 0: a stray start pulse during ISSUE of that element.
   // rst_el >= 0: reset is pulsed during WAIT_ACC of that element.
   task automatic run_seq(input int m, input int k, input int n, input int inj_el,
                          input int rst_el, input int budget, output int cyc);
      bit injected = 0;
      em = m; ek = k; en = n;
      wr_cnt = 0; rd_cnt = 0; exp_i = 0; exp_j = 0; exp_k = 0; term = 0; pend = 0;
      tick();
      start = 1'b1;
      dim_m = 8'(m);
      dim_k = 8'(k);
      dim_n = 8'(n);
      tick();
      start = 1'b0;
      cyc   = 1;
      check("accept_busy", busy, 1);
      check("accept_clear", {done, err}, 2'b00);
      while (!done && cyc < budget) begin
         start = 1'b0;
         if (inj_el >= 0 && !injected && wr_cnt == inj_el && a_rd_en) begin
            start    = 1'b1;
            dim_k    = 8'd0;
            injected = 1;
         end
         if (rst_el >= 0 && wr_cnt == rst_el && pend == 2) begin
            rst_n = 1'b0;
            #1;
            check("rst_outputs_zero", any_out(), 0);
            tick();
            tick();
            rst_n = 1'b1;
            for (int c = 0; c < 6; c++) begin
               tick();
               check("rst_idle_status", {busy, done, err}, 3'b000);
            end
            check("rst_no_write", wr_cnt, rst_el);
            cyc = -1;
            return;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check("done_seen", done, 1);
      check("fin_busy_low", busy, 0);
   endtask

   int cyc;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      dim_m = '0;
      dim_k = '0;
      dim_n = '0;
      mac_never = 0;
      em = 1; ek = 1; en = 1;
      wr_cnt = 0; rd_cnt = 0; exp_i = 0; exp_j = 0; exp_k = 0;
      for (int x = 0; x < 16; x++) b_mem[x] = 32'(x * x + 3);
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", any_out(), 0);
      tick();
      rst_n = 1'b1;

      // Full 4x4x4: 16 elements of 4+1+3+1 cycles plus CHECK and FIN.
      run_seq(4, 4, 4, -1, -1, 1000, cyc);
      check("s444_cycles", cyc, 146);
      check("s444_err", err, 0);
      check("s444_writes", wr_cnt, 16);
      check("s444_reads", rd_cnt, 64);
      repeat (3) tick();
      check("s444_sticky", {busy, done, err}, 3'b010);

      // 1x1x1: single term carries first and last together.
      run_seq(1, 1, 1, -1, -1, 100, cyc);
      check("s111_cycles", cyc, 8);
      check("s111_err", err, 0);
      check("s111_writes", wr_cnt, 1);
      check("s111_reads", rd_cnt, 1);

      // Bad dimensions: K=0, then M above MAX_M.
      run_seq(4, 0, 4, -1, -1, 100, cyc);
      check("k0_cycles", cyc, 2);
      check("k0_err", err, 1);
      check("k0_no_access", {rd_cnt[7:0], wr_cnt[7:0]}, 16'd0);
      run_seq(5, 4, 4, -1, -1, 100, cyc);
      check("m5_cycles", cyc, 2);
      check("m5_err", err, 1);
      check("m5_no_access", {rd_cnt[7:0], wr_cnt[7:0]}, 16'd0);

      // MAC never answers: 255 WAIT_ACC cycles then error.
      mac_never = 1;
      run_seq(1, 1, 1, -1, -1, 400, cyc);
      check("to_cycles", cyc, 259);
      check("to_err", err, 1);
      check("to_writes", wr_cnt, 0);
      mac_never = 0;

      // Stray start while busy is ignored; sequence identical to the first run.
      run_seq(4, 4, 4, 5, -1, 1000, cyc);
      check("inj_cycles", cyc, 146);
      check("inj_err", err, 0);
      check("inj_writes", wr_cnt, 16);
      run_seq(2, 3, 2, -1, -1, 200, cyc);
      check("s232_cycles", cyc, 34);
      check("s232_writes", wr_cnt, 4);

      // Reset during WAIT_ACC of element 7, then a clean rerun.
      run_seq(4, 4, 4, -1, 7, 1000, cyc);
      check("rst_aborted", cyc, -1);
      run_seq(4, 4, 4, -1, -1, 1000, cyc);
      check("post_rst_cycles", cyc, 146);
      check("post_rst_err", err, 0);
      check("post_rst_writes", wr_cnt, 16);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
